dual_cache_mem_controller: RTL and testbench
============================================

// Module: dual_cache_mem_controller
// PURPOSE
// Shared backing-memory controller directly downstream of two data caches. Accepts each
// cache's 25-bit memory request {cmd, data[7:0], addr[15:0]}, round-robin arbitrates, and
// performs a fixed-latency word read or byte write on a 16-bit-word memory. Returns the full
// 16-bit word to the requester and drives the other cache's invalidate address on every write.
// PARAMETERS
// MEM_WORD_BITS  8  log2 of memory depth in 16-bit words; word index = addr[MEM_WORD_BITS:1]
// LATENCY        4  ACCESS-state cycles per request (>=1)
// PORTS
// clock          in   1   rising-edge clock
// reset          in   1   synchronous, active-low
// req0           in   25  cache 0 request: [24]=cmd (0 read,1 write), [23:16]=data, [15:0]=addr
// req0_ready     in   1   cache 0 request valid; held high until response seen
// resp0          out  16  word returned to cache 0 (byte addr&~1 low, addr|1 high)
// resp0_ready    out  1   one-cycle pulse: resp0 valid
// inval0         out  16  invalidate address to cache 0 (from cache 1 writes)
// req1, req1_ready, resp1, resp1_ready, inval1: same as port 0, for cache 1
// BEHAVIOUR
// - Reset (reset==0 at clock edge): state=IDLE; resp0/resp1=0; resp*_ready=0; inval0/inval1=0;
//   last_grant=1 (port 0 wins first tie); armed0/armed1=0; latency counter=0. Memory not cleared.
// - Mid-operation reset aborts any access; a write not yet committed is discarded.
// - Armed flag per port: set when reqN_ready sampled low; cleared when request accepted.
//   Port eligible only if reqN_ready && armedN (cache drops ready one cycle late after response).
// - FSM IDLE: if any port eligible, grant it (both eligible -> port != last_grant); latch req,
//   set last_grant, clear its armed flag, counter=LATENCY-1, go ACCESS. Else stay IDLE.
// - ACCESS: count down; at counter==0 go RESPOND. Inputs ignored during ACCESS/RESPOND.
// - RESPOND (one cycle): read -> respN=mem[idx]. Write -> merge byte into mem[idx]
//   (addr[0]=0 -> [7:0], 1 -> [15:8]), write word back, respN=merged word; and set
//   inval(other port)=latched addr. respN_ready=1 for this cycle only; go IDLE.
// - Latency: request accepted at edge T -> respN_ready high in cycle after edge T+LATENCY+1.
//   Minimum back-to-back acceptance: next IDLE edge after RESPOND.
// - respN holds last value between responses; invalN changes only on a write by other port.
// - Address bits above MEM_WORD_BITS ignored (aliasing by design); addr[0] ignored for reads.
// - Data/cmd taken from latched request; changes on reqN during service have no effect.
// - Only the granted port ever sees resp*_ready; non-granted ready stays low.
// TESTING
// 1 Reset, cache0 write {1,8'hAB,16'h0010} -> after LATENCY+1 cycles resp0=16'h??AB,
//   resp0_ready 1-cycle pulse, inval1=16'h0010, inval0 unchanged (0).
// 2 Then cache0 write {1,8'hCD,16'h0011}, cache1 read 16'h0010 -> resp0=16'hCDAB, then
//   resp1=16'hCDAB; inval1=16'h0011.
// 3 Both ports raise ready same cycle after reset -> port 0 served first, port 1 next;
//   repeat simultaneous -> alternates 0,1,0,1.
// 4 Port 0 holds req0_ready high one cycle after response pulse -> no second grant until
//   req0_ready seen low (armed check).
// 5 Assert reset during ACCESS of write {1,8'h55,16'h0020} -> no resp pulse, later read of
//   16'h0020 returns prior contents (write discarded), all outputs at reset values.
// 6 Write addr 16'h0210 with MEM_WORD_BITS=8 -> read of 16'h0010 returns that byte (alias).

Source files
------------

// File: rtl/dual_cache_mem_controller.sv
// Shared 16-bit-word backing memory for two caches: round-robin arbitration, fixed-latency
// word read / byte write, full-word response, and cross-cache invalidate on writes.
module dual_cache_mem_controller #(
   parameter int MEM_WORD_BITS = 8,
   parameter int LATENCY       = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [24:0] req0,
   input  logic        req0_ready,
   output logic [15:0] resp0,
   output logic        resp0_ready,
   output logic [15:0] inval0,
   input  logic [24:0] req1,
   input  logic        req1_ready,
   output logic [15:0] resp1,
   output logic        resp1_ready,
   output logic [15:0] inval1
);

   localparam int DEPTH = 1 << MEM_WORD_BITS;
   localparam int CW    = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   state_t                   state_q, state_d;
   logic                     last_grant_q, last_grant_d;
   logic                     grant_q, grant_d;
   logic                     armed0_q, armed0_d;
   logic                     armed1_q, armed1_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [24:0]              req_q, req_d;
   logic [15:0]              resp0_q, resp0_d;
   logic [15:0]              resp1_q, resp1_d;
   logic                     resp0_ready_q, resp0_ready_d;
   logic                     resp1_ready_q, resp1_ready_d;
   logic [15:0]              inval0_q, inval0_d;
   logic [15:0]              inval1_q, inval1_d;
   logic [15:0]              mem_q [DEPTH];

   logic                     elig0, elig1, pick, mem_we;
   logic [MEM_WORD_BITS-1:0] mem_idx;
   logic [15:0]              rd_word, wr_word, out_word;

   // Upper address bits are dropped on purpose, so addresses alias modulo the memory size.
   assign mem_idx = req_q[MEM_WORD_BITS:1];
   assign rd_word = mem_q[mem_idx];
   assign wr_word = req_q[0] ? {req_q[23:16], rd_word[7:0]} : {rd_word[15:8], req_q[23:16]};
   assign out_word = req_q[24] ? wr_word : rd_word;

   // A cache only re-arms after it has been seen dropping ready, since it lowers it a cycle late.
   assign elig0 = req0_ready && armed0_q;
   assign elig1 = req1_ready && armed1_q;

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_d       = grant_q;
      armed0_d      = armed0_q | ~req0_ready;
      armed1_d      = armed1_q | ~req1_ready;
      cnt_d         = cnt_q;
      req_d         = req_q;
      resp0_d       = resp0_q;
      resp1_d       = resp1_q;
      resp0_ready_d = 1'b0;
      resp1_ready_d = 1'b0;
      inval0_d      = inval0_q;
      inval1_d      = inval1_q;
      mem_we        = 1'b0;
      pick          = (elig0 && elig1) ? ~last_grant_q : elig1;
      case (state_q)
         IDLE: begin
            if (elig0 || elig1) begin
               grant_d      = pick;
               last_grant_d = pick;
               req_d        = pick ? req1 : req0;
               if (pick) armed1_d = 1'b0;
               else      armed0_d = 1'b0;
               cnt_d        = CW'(LATENCY - 1);
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) state_d = RESPOND;
            else             cnt_d   = cnt_q - CW'(1);
         end
         RESPOND: begin
            mem_we = req_q[24];
            if (grant_q) begin
               resp1_d       = out_word;
               resp1_ready_d = 1'b1;
               if (req_q[24]) inval0_d = req_q[15:0];
            end else begin
               resp0_d       = out_word;
               resp0_ready_d = 1'b1;
               if (req_q[24]) inval1_d = req_q[15:0];
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= IDLE;
         last_grant_q  <= 1'b1;
         grant_q       <= 1'b0;
         armed0_q      <= 1'b0;
         armed1_q      <= 1'b0;
         cnt_q         <= '0;
         req_q         <= '0;
         resp0_q       <= '0;
         resp1_q       <= '0;
         resp0_ready_q <= 1'b0;
         resp1_ready_q <= 1'b0;
         inval0_q      <= '0;
         inval1_q      <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         grant_q       <= grant_d;
         armed0_q      <= armed0_d;
         armed1_q      <= armed1_d;
         cnt_q         <= cnt_d;
         req_q         <= req_d;
         resp0_q       <= resp0_d;
         resp1_q       <= resp1_d;
         resp0_ready_q <= resp0_ready_d;
         resp1_ready_q <= resp1_ready_d;
         inval0_q      <= inval0_d;
         inval1_q      <= inval1_d;
      end
   end

   // Memory contents survive reset; a reset on the commit edge discards the pending write.
   always_ff @(posedge clock) begin
      if (reset && mem_we) mem_q[mem_idx] <= wr_word;
   end

   assign resp0       = resp0_q;
   assign resp1       = resp1_q;
   assign resp0_ready = resp0_ready_q;
   assign resp1_ready = resp1_ready_q;
   assign inval0      = inval0_q;
   assign inval1      = inval1_q;

endmodule

// File: tb/tb_dual_cache_mem_controller.sv
// Directed bench for dual_cache_mem_controller: vector table plus arbitration, re-arm,
// mid-access reset and aliasing sequences.
module tb_dual_cache_mem_controller;

   localparam int LAT = 4;

   logic        clock;
   logic        reset;
   logic [24:0] req0, req1;
   logic        req0_ready, req1_ready;
   logic [15:0] resp0, resp1, inval0, inval1;
   logic        resp0_ready, resp1_ready;

   int checks = 0;
   int errors = 0;
   int order [8];
   int oi = 0;

   typedef struct {
      bit          p;
      bit          cmd;
      logic [7:0]  dat;
      logic [15:0] addr;
      logic [15:0] exp;
      logic [15:0] mask;
      logic [15:0] ei0;
      logic [15:0] ei1;
   } vec_t;

   vec_t vecs [11];

   dual_cache_mem_controller #(.MEM_WORD_BITS(8), .LATENCY(LAT)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req0_ready(req0_ready), .resp0(resp0), .resp0_ready(resp0_ready),
      .inval0(inval0),
      .req1(req1), .req1_ready(req1_ready), .resp1(resp1), .resp1_ready(resp1_ready),
      .inval1(inval1)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic get_rdy(input bit p);
      return p ? resp1_ready : resp0_ready;
   endfunction

   function automatic logic [15:0] get_resp(input bit p);
      return p ? resp1 : resp0;
   endfunction

   task automatic set_req(input bit p, input logic [24:0] r, input logic rdy);
      if (p) begin
         req1 = r; req1_ready = rdy;
      end else begin
         req0 = r; req0_ready = rdy;
      end
   endtask

   task automatic wait_pulse(input bit p, output int n, output bit other);
      n = 0;
      other = 1'b0;
      while (n < 40) begin
         tick();
         n++;
         if (get_rdy(!p)) other = 1'b1;
         if (get_rdy(p)) break;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      bit other;
      set_req(v.p, {v.cmd, v.dat, v.addr}, 1'b1);
      wait_pulse(v.p, n, other);
      chk("pulse_seen", 32'(get_rdy(v.p)), 32'd1);
      chk("latency", 32'(n), 32'(LAT + 2));
      chk("resp", 32'(get_resp(v.p) & v.mask), 32'(v.exp & v.mask));
      chk("inval0", 32'(inval0), 32'(v.ei0));
      chk("inval1", 32'(inval1), 32'(v.ei1));
      chk("other_rdy_low", 32'(other), 32'd0);
      tick();
      chk("pulse_width", 32'(get_rdy(v.p)), 32'd0);
      set_req(v.p, {v.cmd, v.dat, v.addr}, 1'b0);
      tick();
   endtask

   task automatic tie_round();
      bit pend0, pend1, d0, d1;
      int n;
      pend0 = 0; pend1 = 0; d0 = 0; d1 = 0; n = 0;
      req0 = {1'b0, 8'h00, 16'h0041};
      req1 = {1'b0, 8'h00, 16'h0010};
      req0_ready = 1'b1;
      req1_ready = 1'b1;
      while (!(d0 && d1) && n < 60) begin
         tick();
         n++;
         if (pend0) begin req0_ready = 1'b0; pend0 = 0; end
         if (pend1) begin req1_ready = 1'b0; pend1 = 0; end
         if (resp0_ready) begin
            if (oi < 8) order[oi] = 0;
            oi++;
            chk("tie_resp0", 32'(resp0), 32'h77EE);
            pend0 = 1; d0 = 1;
         end
         if (resp1_ready) begin
            if (oi < 8) order[oi] = 1;
            oi++;
            chk("tie_resp1", 32'(resp1), 32'hCD99);
            pend1 = 1; d1 = 1;
         end
      end
      chk("tie_both_served", 32'(d0 && d1), 32'd1);
      tick();
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      tick();
   endtask

   initial begin
      int n;
      bit other, seen;

      vecs[0]  = '{1'b0, 1'b1, 8'hAB, 16'h0010, 16'h00AB, 16'h00FF, 16'h0000, 16'h0010};
      vecs[1]  = '{1'b0, 1'b1, 8'hCD, 16'h0011, 16'hCDAB, 16'hFFFF, 16'h0000, 16'h0011};
      vecs[2]  = '{1'b1, 1'b0, 8'h00, 16'h0010, 16'hCDAB, 16'hFFFF, 16'h0000, 16'h0011};
      vecs[3]  = '{1'b1, 1'b1, 8'hEE, 16'h0040, 16'h00EE, 16'h00FF, 16'h0040, 16'h0011};
      vecs[4]  = '{1'b1, 1'b1, 8'h77, 16'h0041, 16'h77EE, 16'hFFFF, 16'h0041, 16'h0011};
      vecs[5]  = '{1'b0, 1'b0, 8'h00, 16'h0041, 16'h77EE, 16'hFFFF, 16'h0041, 16'h0011};
      vecs[6]  = '{1'b0, 1'b1, 8'h11, 16'h0020, 16'h0011, 16'h00FF, 16'h0041, 16'h0020};
      vecs[7]  = '{1'b0, 1'b1, 8'h22, 16'h0021, 16'h2211, 16'hFFFF, 16'h0041, 16'h0021};
      vecs[8]  = '{1'b1, 1'b1, 8'h99, 16'h0210, 16'hCD99, 16'hFFFF, 16'h0210, 16'h0021};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 16'h0010, 16'hCD99, 16'hFFFF, 16'h0210, 16'h0021};
      vecs[10] = '{1'b1, 1'b0, 8'h00, 16'hFE11, 16'hCD99, 16'hFFFF, 16'h0210, 16'h0021};

      reset = 1'b0;
      req0 = '0; req1 = '0;
      req0_ready = 1'b0; req1_ready = 1'b0;
      repeat (3) tick();
      chk("rst_resp0", 32'(resp0), 32'h0);
      chk("rst_resp1", 32'(resp1), 32'h0);
      chk("rst_rdy0", 32'(resp0_ready), 32'h0);
      chk("rst_rdy1", 32'(resp1_ready), 32'h0);
      chk("rst_inval0", 32'(inval0), 32'h0);
      chk("rst_inval1", 32'(inval1), 32'h0);
      reset = 1'b1;
      tick();
      tick();

      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // Simultaneous requests alternate 0,1 then 0,1 again.
      tie_round();
      tie_round();
      chk("tie_count", 32'(oi), 32'd4);
      chk("tie_order0", 32'(order[0]), 32'd0);
      chk("tie_order1", 32'(order[1]), 32'd1);
      chk("tie_order2", 32'(order[2]), 32'd0);
      chk("tie_order3", 32'(order[3]), 32'd1);

      // Ready held high after a response must not regrant until it is seen low.
      set_req(1'b0, {1'b0, 8'h00, 16'h0020}, 1'b1);
      wait_pulse(1'b0, n, other);
      chk("hold_first_resp", 32'(resp0), 32'h2211);
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (resp0_ready || resp1_ready) seen = 1'b1;
      end
      chk("hold_no_regrant", 32'(seen), 32'd0);
      req0_ready = 1'b0;
      tick();
      req0 = {1'b0, 8'h00, 16'h0020};
      req0_ready = 1'b1;
      tick();
      tick();
      req0 = {1'b1, 8'hFF, 16'h0020};
      wait_pulse(1'b0, n, other);
      chk("rearm_latency", 32'(n), 32'(LAT));
      chk("rearm_resp_latched", 32'(resp0), 32'h2211);
      chk("rearm_inval1", 32'(inval1), 32'h0021);
      tick();
      req0_ready = 1'b0;
      tick();

      // Reset in the middle of a write discards it.
      set_req(1'b0, {1'b1, 8'h55, 16'h0020}, 1'b1);
      seen = 1'b0;
      repeat (3) begin
         tick();
         if (resp0_ready || resp1_ready) seen = 1'b1;
      end
      reset = 1'b0;
      req0_ready = 1'b0;
      tick();
      if (resp0_ready || resp1_ready) seen = 1'b1;
      chk("mid_rst_resp0", 32'(resp0), 32'h0);
      chk("mid_rst_resp1", 32'(resp1), 32'h0);
      chk("mid_rst_inval0", 32'(inval0), 32'h0);
      chk("mid_rst_inval1", 32'(inval1), 32'h0);
      reset = 1'b1;
      repeat (8) begin
         tick();
         if (resp0_ready || resp1_ready) seen = 1'b1;
      end
      chk("mid_rst_no_pulse", 32'(seen), 32'd0);
      run_vec('{1'b1, 1'b0, 8'h00, 16'h0020, 16'h2211, 16'hFFFF, 16'h0000, 16'h0000});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
